clk_div_mgr: RTL and testbench
==============================

Name: clk_div_mgr

Overview:
- Parametrised multi-channel programmable clock generator.
- Derives CH_NUM divided clocks and matching one-cycle clock-enable strobes from one fabric clock, e.g. the video PLL output.
- Divide ratio and duty are reconfigurable at run time through a valid/ready port. New settings take effect only at a period boundary, so outputs never glitch.
- Each channel has a locked flag that asserts once its output has run stably for LOCK_PERIODS periods.

Parameters:
- CH_NUM, 2, number of output channels (1..8).
- DIV_W, 8, width of the divide and duty fields.
- DIV_INIT, 4, divide ratio loaded into every channel at reset.
- LOCK_PERIODS, 4, complete periods after a (re)start before locked asserts (1..15).

Ports:
- clk  input  1  fabric clock.
- rst_n  input  1  asynchronous active-low reset.
- cfg_valid  input  1  configuration request.
- cfg_ready  output  1  request accepted this cycle when high with cfg_valid.
- cfg_ch  input  3  target channel index.
- cfg_div  input  DIV_W  period in clk cycles.
- cfg_duty  input  DIV_W  high-time in clk cycles.
- cfg_err  output  1  one-cycle pulse: request dropped, cfg_ch >= CH_NUM.
- clk_out  output  CH_NUM  divided clocks, registered.
- clk_en  output  CH_NUM  one-cycle strobe on the last cycle of each period.
- locked  output  CH_NUM  channel stable.

Behaviour:
- Reset (async assert, sync release):
  - cnt=0, div=DIV_INIT, duty=DIV_INIT/2, pending=0, lock_cnt=0.
  - All outputs 0: clk_out, clk_en, locked, cfg_err.
- Sanitising, applied when a config is accepted:
  - Effective P = max(cfg_div, 2).
  - Effective H = cfg_duty clamped to 1..P-1.
  - The stored values are the sanitised ones.
- Per-channel counter:
  - cnt counts 0..P-1, then wraps to 0.
  - clk_out[i] <= (cnt < H), so clk_out trails cnt by one cycle.
  - clk_en[i] <= (cnt == P-1).
  - Result: clk_out is high for H cycles and low for P-H cycles. clk_en pulses once per P cycles, aligned with the last low cycle of clk_out.
- Config handshake:
  - cfg_ready = !pending[cfg_ch] when cfg_ch < CH_NUM; otherwise cfg_ready = 1.
  - This is combinational from cfg_ch.
  - Accept occurs when cfg_valid && cfg_ready.
  - Accept with cfg_ch out of range: request dropped; cfg_err pulses the next cycle.
  - Accept with sanitised values equal to the active values and nothing pending: no-op. pending stays 0; locked and the counter are unaffected.
  - Otherwise the values are stored in the channel's shadow registers and pending is set.
- Apply rule:
  - When pending && cnt==P-1, the shadow values become active on the next cycle, cnt goes to 0, pending clears, lock_cnt clears, and locked drops.
  - The clk_en for the wrapping period still fires for the old period.
  - A new accept while pending is impossible because cfg_ready is low.
  - An accept on the same cycle pending clears sees cfg_ready low; it is taken on the following cycle.
- Lock:
  - lock_cnt increments on each clk_en of the channel, saturating at LOCK_PERIODS.
  - locked[i] = (lock_cnt == LOCK_PERIODS), registered.
  - After reset, first locked = 1 occurs the cycle after the LOCK_PERIODS-th clk_en.
- Channels are fully independent; simultaneous applies on several channels are allowed.
- Reset mid-period: everything returns to reset values immediately, and any pending config is discarded.

Optional Feature:
- Macro: CLK_DIV_MGR_PHASE_ALIGN_EN.
- When defined: adds input port sync_req (1 bit).
  - sync_req high for one cycle forces every channel's cnt to 0 on the next cycle. All channels become phase-aligned.
  - Pending configs are applied at that same instant.
  - lock_cnt clears and locked drops on all channels.
  - sync_req has priority over normal wrap.
- When undefined: port absent; channels free-run and are only aligned by reset.

Test Plan:
- Reset release, defaults (DIV_INIT=4):
  - clk_out[0] pattern 1,1,0,0 repeating.
  - clk_en[0] every 4th cycle.
  - locked[0] rises the cycle after the 4th clk_en.
- Reconfigure ch1 to div=5, duty=2 mid-period:
  - cfg_ready drops until the current period ends.
  - New pattern 1,1,0,0,0 starts exactly at the wrap with no short pulse.
  - locked[1] drops, then re-asserts after 4 periods of 5 cycles.
  - ch0 is unaffected.
- Config div=1, duty=0 on ch0: applied as P=2, H=1; clk_out toggles every cycle.
- Config div=6, duty=9: H clamped to 5; clk_out high 5 cycles, low 1 cycle.
- cfg_ch=5 with CH_NUM=2:
  - cfg_ready=1; cfg_err pulses one cycle.
  - No channel changes.
- Re-send the identical active config: accepted with no pending, locked stays 1, and the phase is unchanged.
- PHASE_ALIGN_EN build: channels at div 3 and 5, pulse sync_req.
  - Both counters restart on the same cycle.
  - clk_en coincides every 15 cycles thereafter.
  - locked drops on both channels.

Source files
------------

// File: rtl/clk_div_mgr.sv
// Multi-channel programmable clock divider: run-time reconfigurable ratio/duty, glitch-free apply at period wrap, per-channel lock flag.
// Optional macro CLK_DIV_MGR_PHASE_ALIGN_EN adds sync_req, which restarts every channel on the same cycle.
module clk_div_mgr #(
    parameter int CH_NUM       = 2,
    parameter int DIV_W        = 8,
    parameter int DIV_INIT     = 4,
    parameter int LOCK_PERIODS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_duty,
    output logic              cfg_err,
`ifdef CLK_DIV_MGR_PHASE_ALIGN_EN
    input  logic              sync_req,
`endif
    output logic [CH_NUM-1:0] clk_out,
    output logic [CH_NUM-1:0] clk_en,
    output logic [CH_NUM-1:0] locked
);

    localparam int                LOCK_W   = 4;
    localparam logic [DIV_W-1:0]  DIV_RST  = DIV_W'(DIV_INIT);
    localparam logic [DIV_W-1:0]  DUTY_RST = DIV_W'(DIV_INIT / 2);
    localparam logic [DIV_W-1:0]  DIV_MIN  = DIV_W'(2);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_PERIODS);

    logic [DIV_W-1:0]  san_div;
    logic [DIV_W-1:0]  san_duty;
    logic [CH_NUM-1:0] ch_sel;
    logic [CH_NUM-1:0] ch_pending;
    logic              ch_in_range;
    logic              accept;
    logic              sync_now;
    logic              cfg_err_d;
    logic              cfg_err_q;

`ifdef CLK_DIV_MGR_PHASE_ALIGN_EN
    assign sync_now = sync_req;
`else
    assign sync_now = 1'b0;
`endif

    // Period is at least 2 and high time sits in 1..P-1, so every period has both levels.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        san_div  = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
        san_duty = cfg_duty;
        if (cfg_duty == '0) begin
            san_duty = DIV_W'(1);
        end else if (cfg_duty >= san_div) begin
            san_duty = san_div - DIV_W'(1);
        end
    end

    // Out-of-range requests are always accepted so the master never stalls; they are dropped.
    always_comb begin
        ch_in_range = 1'b0;
        cfg_ready   = 1'b1;
        ch_sel      = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (cfg_ch == 3'(i)) begin
                ch_in_range = 1'b1;
                ch_sel[i]   = 1'b1;
                cfg_ready   = !ch_pending[i];
            end
        end
    end

    assign accept    = cfg_valid && cfg_ready;
    assign cfg_err_d = accept && !ch_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic [DIV_W-1:0]  cnt_q, cnt_d;
        logic [DIV_W-1:0]  div_q, div_d;
        logic [DIV_W-1:0]  duty_q, duty_d;
        logic [DIV_W-1:0]  sdiv_q, sdiv_d;
        logic [DIV_W-1:0]  sduty_q, sduty_d;
        logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
        logic              pending_q, pending_d;
        logic              clk_out_q, clk_out_d;
        logic              clk_en_q, clk_en_d;
        logic              locked_q, locked_d;
        logic              wrap;
        logic              restart;
        logic              same_cfg;

        always_comb begin
            wrap       = (cnt_q == div_q - DIV_W'(1));
            restart    = (pending_q && wrap) || sync_now;
            same_cfg   = (san_div == div_q) && (san_duty == duty_q);
            div_d      = div_q;
            duty_d     = duty_q;
            sdiv_d     = sdiv_q;
            sduty_d    = sduty_q;
            pending_d  = pending_q;
            lock_cnt_d = lock_cnt_q;
            locked_d   = (lock_cnt_q == LOCK_MAX);
            clk_out_d  = (cnt_q < duty_q);
            clk_en_d   = wrap;
            cnt_d      = (wrap || sync_now) ? '0 : cnt_q + DIV_W'(1);

            // The wrap's clk_en still belongs to the old period; only the next one uses the new ratio.
            if (restart) begin
                if (pending_q) begin
                    div_d  = sdiv_q;
                    duty_d = sduty_q;
                end
                pending_d  = 1'b0;
                lock_cnt_d = '0;
                locked_d   = 1'b0;
            end else if (wrap && lock_cnt_q != LOCK_MAX) begin
                lock_cnt_d = lock_cnt_q + LOCK_W'(1);
            end

            if (accept && ch_sel[i] && !same_cfg) begin
                sdiv_d    = san_div;
                sduty_d   = san_duty;
                pending_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q      <= '0;
                div_q      <= DIV_RST;
                duty_q     <= DUTY_RST;
                // NOTE: shadow registers are reset as well, so an apply can never load unknown values.
                sdiv_q     <= DIV_RST;
                sduty_q    <= DUTY_RST;
                pending_q  <= 1'b0;
                lock_cnt_q <= '0;
                clk_out_q  <= 1'b0;
                clk_en_q   <= 1'b0;
                locked_q   <= 1'b0;
            end else begin
                cnt_q      <= cnt_d;
                div_q      <= div_d;
                duty_q     <= duty_d;
                sdiv_q     <= sdiv_d;
                sduty_q    <= sduty_d;
                pending_q  <= pending_d;
                lock_cnt_q <= lock_cnt_d;
                clk_out_q  <= clk_out_d;
                clk_en_q   <= clk_en_d;
                locked_q   <= locked_d;
            end
        end

        assign ch_pending[i] = pending_q;
        assign clk_out[i]    = clk_out_q;
        assign clk_en[i]     = clk_en_q;
        assign locked[i]     = locked_q;
    end

endmodule

// File: tb/tb_clk_div_mgr.sv
// Scoreboard bench for clk_div_mgr: expected output tuples are queued per cycle when stimulus is driven,
// then popped and compared at each falling edge.
module tb_clk_div_mgr;

    localparam int CH_NUM = 2;
    localparam int DIV_W  = 8;
    localparam int LOCK   = 4;

    typedef struct packed {
        logic [CH_NUM-1:0] co;
        logic [CH_NUM-1:0] ce;
        logic [CH_NUM-1:0] lk;
        logic              rdy;
        logic              err;
    } exp_t;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [2:0]        cfg_ch    = '0;
    logic [DIV_W-1:0]  cfg_div   = '0;
    logic [DIV_W-1:0]  cfg_duty  = '0;
    logic              cfg_ready;
    logic              cfg_err;
    logic [CH_NUM-1:0] clk_out;
    logic [CH_NUM-1:0] clk_en;
    logic [CH_NUM-1:0] locked;
`ifdef CLK_DIV_MGR_PHASE_ALIGN_EN
    logic              sync_req  = 1'b0;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   k        = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    clk_div_mgr #(
        .CH_NUM(CH_NUM), .DIV_W(DIV_W), .DIV_INIT(4), .LOCK_PERIODS(LOCK)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .cfg_duty(cfg_duty),
        .cfg_err(cfg_err),
`ifdef CLK_DIV_MGR_PHASE_ALIGN_EN
        .sync_req(sync_req),
`endif
        .clk_out(clk_out),
        .clk_en(clk_en),
        .locked(locked)
    );

    // Cycle k (k >= start) of a pattern with period p and high time h that begins at cycle start.
    function automatic logic pat_co(int kk, int start, int p, int h);
        return ((kk - start) % p) < h;
    endfunction

    function automatic logic pat_ce(int kk, int start, int p);
        return ((kk - start) % p) == (p - 1);
    endfunction

    // Both channels free-running at the reset ratio 4, duty 2, counted from reset release.
    function automatic exp_t dflt(int kk);
        exp_t e;
        e.co  = {CH_NUM{pat_co(kk, 1, 4, 2)}};
        e.ce  = {CH_NUM{pat_ce(kk, 1, 4)}};
        e.lk  = {CH_NUM{kk >= 1 + LOCK * 4}};
        e.rdy = 1'b1;
        e.err = 1'b0;
        return e;
    endfunction

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_duty  = '0;
`ifdef CLK_DIV_MGR_PHASE_ALIGN_EN
        sync_req  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
    endtask

    task automatic test_reset();
        exp_t obs, e;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        repeat (2) @(negedge clk);
        obs = {clk_out, clk_en, locked, cfg_ready, cfg_err};
        e   = '{co: '0, ce: '0, lk: '0, rdy: 1'b1, err: 1'b0};
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_state: got %b, want %b", obs, e);
        end
        for (int kk = 1; kk <= 20; kk++) sb_q.push_back(dflt(kk));
        rst_n = 1'b1;
        k     = 0;
        while (sb_q.size() > 0) begin
            step();
            obs = {clk_out, clk_en, locked, cfg_ready, cfg_err};
            e   = sb_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_pattern k=%0d: got co=%b ce=%b lk=%b rdy=%b err=%b, want co=%b ce=%b lk=%b rdy=%b err=%b",
                         k, obs.co, obs.ce, obs.lk, obs.rdy, obs.err, e.co, e.ce, e.lk, e.rdy, e.err);
            end
        end
        // Asynchronous assertion mid-period must clear outputs without waiting for a clock edge.
        #2 rst_n = 1'b0;
        #1;
        obs = {clk_out, clk_en, locked, cfg_ready, cfg_err};
        e   = '{co: '0, ce: '0, lk: '0, rdy: 1'b1, err: 1'b0};
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL async_reset: got %b, want %b", obs, e);
        end
    endtask

    // Config driven at cycle d; with the default ratio 4 it applies on the first wrap edge m >= d+2.
    task automatic test_apply(input string name, input int ch, input int div, input int duty,
                              input int p, input int h, input int d);
        exp_t obs, e;
        int   m, start, last;
        do_reset();
        while (k < d) step();
        m = d + 2;
        while (m % 4 != 0) m++;
        start = m + 1;
        last  = start + LOCK * p + 2;
        cfg_ch    = 3'(ch);
        cfg_div   = DIV_W'(div);
        cfg_duty  = DIV_W'(duty);
        cfg_valid = 1'b1;
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_before_accept: got %b, want 1", name, cfg_ready);
        end
        for (int kk = d + 1; kk <= last; kk++) begin
            e = dflt(kk);
            if (kk == m) e.lk[ch] = 1'b0;
            if (kk >= start) begin
                e.co[ch] = pat_co(kk, start, p, h);
                e.ce[ch] = pat_ce(kk, start, p);
                e.lk[ch] = (kk >= start + LOCK * p);
            end
            e.rdy = !(kk > d && kk < m);
            sb_q.push_back(e);
        end
        while (sb_q.size() > 0) begin
            step();
            obs = {clk_out, clk_en, locked, cfg_ready, cfg_err};
            e   = sb_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s k=%0d: got co=%b ce=%b lk=%b rdy=%b err=%b, want co=%b ce=%b lk=%b rdy=%b err=%b",
                         name, k, obs.co, obs.ce, obs.lk, obs.rdy, obs.err, e.co, e.ce, e.lk, e.rdy, e.err);
            end
            cfg_valid = 1'b0;
        end
    endtask

    task automatic test_bad_ch();
        exp_t obs, e;
        do_reset();
        while (k < 2) step();
        cfg_ch    = 3'd5;
        cfg_div   = 8'd7;
        cfg_duty  = 8'd3;
        cfg_valid = 1'b1;
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_ch ready: got %b, want 1", cfg_ready);
        end
        for (int kk = 3; kk <= 22; kk++) begin
            e     = dflt(kk);
            e.err = (kk == 3);
            sb_q.push_back(e);
        end
        while (sb_q.size() > 0) begin
            step();
            obs = {clk_out, clk_en, locked, cfg_ready, cfg_err};
            e   = sb_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL bad_ch k=%0d: got co=%b ce=%b lk=%b rdy=%b err=%b, want co=%b ce=%b lk=%b rdy=%b err=%b",
                         k, obs.co, obs.ce, obs.lk, obs.rdy, obs.err, e.co, e.ce, e.lk, e.rdy, e.err);
            end
            cfg_valid = 1'b0;
        end
    endtask

    task automatic test_same_cfg();
        exp_t obs, e;
        do_reset();
        while (k < 21) step();
        cfg_ch    = 3'd0;
        cfg_div   = 8'd4;
        cfg_duty  = 8'd2;
        cfg_valid = 1'b1;
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cfg ready: got %b, want 1", cfg_ready);
        end
        for (int kk = 22; kk <= 40; kk++) sb_q.push_back(dflt(kk));
        while (sb_q.size() > 0) begin
            step();
            obs = {clk_out, clk_en, locked, cfg_ready, cfg_err};
            e   = sb_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL same_cfg k=%0d: got co=%b ce=%b lk=%b rdy=%b err=%b, want co=%b ce=%b lk=%b rdy=%b err=%b",
                         k, obs.co, obs.ce, obs.lk, obs.rdy, obs.err, e.co, e.ce, e.lk, e.rdy, e.err);
            end
            cfg_valid = 1'b0;
        end
    endtask

`ifdef CLK_DIV_MGR_PHASE_ALIGN_EN
    task automatic test_phase_align();
        exp_t obs, e;
        do_reset();
        step();
        cfg_ch    = 3'd0;
        cfg_div   = 8'd3;
        cfg_duty  = 8'd1;
        cfg_valid = 1'b1;
        step();
        cfg_ch    = 3'd1;
        cfg_div   = 8'd5;
        cfg_duty  = 8'd2;
        step();
        cfg_valid = 1'b0;
        while (k < 10) step();
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        n_checks++;
        if (locked !== '0) begin
            n_fail++;
            $display("FAIL phase_align locked_drop: got %b, want 00", locked);
        end
        for (int kk = 12; kk <= 45; kk++) begin
            e.co  = {pat_co(kk, 12, 5, 2), pat_co(kk, 12, 3, 1)};
            e.ce  = {pat_ce(kk, 12, 5), pat_ce(kk, 12, 3)};
            e.lk  = {kk >= 12 + LOCK * 5, kk >= 12 + LOCK * 3};
            e.rdy = 1'b1;
            e.err = 1'b0;
            sb_q.push_back(e);
        end
        while (sb_q.size() > 0) begin
            step();
            obs = {clk_out, clk_en, locked, cfg_ready, cfg_err};
            e   = sb_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL phase_align k=%0d: got co=%b ce=%b lk=%b, want co=%b ce=%b lk=%b",
                         k, obs.co, obs.ce, obs.lk, e.co, e.ce, e.lk);
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_apply("reconfig_ch1", 1, 5, 2, 5, 2, 21);
        test_apply("min_clamp", 0, 1, 0, 2, 1, 1);
        test_apply("duty_clamp", 0, 6, 9, 6, 5, 1);
        test_bad_ch();
        test_same_cfg();
`ifdef CLK_DIV_MGR_PHASE_ALIGN_EN
        test_phase_align();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
